// File: rtl/alu_pkg.sv
// Shared ALU definitions: CVNZ flag positions, update masks,
// and branch condition encodings used by the ALU ops and writeback.
package alu_pkg;

   localparam int C_BIT = 3;
   localparam int V_BIT = 2;
   localparam int N_BIT = 1;
   localparam int Z_BIT = 0;

   localparam logic [3:0] C_MASK = 4'b1000;
   localparam logic [3:0] V_MASK = 4'b0100;
   localparam logic [3:0] N_MASK = 4'b0010;
   localparam logic [3:0] Z_MASK = 4'b0001;

   typedef enum logic [2:0] {
      COND_AL = 3'd0,
      COND_EQ = 3'd1,
      COND_NE = 3'd2,
      COND_MI = 3'd3,
      COND_PL = 3'd4,
      COND_CS = 3'd5,
      COND_VS = 3'd6,
      COND_GE = 3'd7
   } cond_e;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers.
// Push while full and pop while empty are ignored.
module wb_fifo2 #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wptr_q, wptr_d;
   logic         rptr_q, rptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   assign do_push = push && (count_q != 2'd2);
   assign do_pop  = pop && (count_q != 2'd0);
   assign head    = mem_q[rptr_q];
   assign count   = count_q;

   // Next pointers, occupancy and storage write.
   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wptr_q] = din;
         wptr_d        = ~wptr_q;
      end
      if (do_pop) begin
         rptr_d = ~rptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   // State register; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: buffers results, commits one per cycle into
// acc/ccr with masked flag merge, and evaluates branch conditions.
module alu_writeback
   import alu_pkg::*;
#(
   parameter int OP_SIZE = 4,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_SIZE-1:0] in_r,
   input  logic [3:0]         in_flags,
   input  logic [3:0]         in_mask,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [OP_SIZE-1:0] acc,
   output logic [3:0]         ccr,
   input  logic               ccr_clr,
   input  logic [2:0]         cond_sel,
   output logic               cond_true,
   output logic [1:0]         count
);

   localparam int         W        = OP_SIZE + 8;
   localparam logic [1:0] FULL_LVL = 2'(DEPTH);

   logic [W-1:0]       head;
   logic [OP_SIZE-1:0] hd_r;
   logic [3:0]         hd_flags;
   logic [3:0]         hd_mask;
   logic               push, commit;

   logic [OP_SIZE-1:0] acc_q, acc_d;
   logic [3:0]         ccr_q, ccr_d;
   logic               ov_q, ov_d;
   logic [3:0]         ccr_base;

   assign in_ready = !rst && (count != FULL_LVL);
   assign push     = in_valid && in_ready;
   assign commit   = !rst && (count != 2'd0) && out_ready;

   assign hd_r     = head[W-1 -: OP_SIZE];
   assign hd_flags = head[7:4];
   assign hd_mask  = head[3:0];

   wb_fifo2 #(.W(W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (commit),
      .din   ({in_r, in_flags, in_mask}),
      .head  (head),
      .count (count)
   );

   // Commit path: clear-then-merge of the flags the op updates.
   always_comb begin
      ccr_base = ccr_clr ? 4'b0000 : ccr_q;
      acc_d    = acc_q;
      ccr_d    = ccr_base;
      ov_d     = 1'b0;
      if (commit) begin
         acc_d = hd_r;
         ccr_d = (ccr_base & ~hd_mask) | (hd_flags & hd_mask);
         ov_d  = 1'b1;
      end
   end

   // Architectural state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         ccr_q <= 4'b0000;
         ov_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ccr_q <= ccr_d;
         ov_q  <= ov_d;
      end
   end

   assign acc       = acc_q;
   assign ccr       = ccr_q;
   assign out_valid = ov_q;

   // Branch condition on the committed ccr only.
   always_comb begin
      cond_true = 1'b0;
      unique case (cond_e'(cond_sel))
         COND_AL: cond_true = 1'b1;
         COND_EQ: cond_true = ccr_q[Z_BIT];
         COND_NE: cond_true = !ccr_q[Z_BIT];
         COND_MI: cond_true = ccr_q[N_BIT];
         COND_PL: cond_true = !ccr_q[N_BIT];
         COND_CS: cond_true = ccr_q[C_BIT];
         COND_VS: cond_true = ccr_q[V_BIT];
         COND_GE: cond_true = (ccr_q[N_BIT] == ccr_q[V_BIT]);
      endcase
   end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the ALU operation modules (and, add, or, ...). It accepts each operation's result and CVNZ flags through a valid/ready handshake. Results are buffered in a 2-entry FIFO and committed one per cycle into the accumulator and the condition code register. On commit, only the flags the operation declares it updates are merged; for example, OR leaves C and V untouched. A combinational condition evaluator on the committed CCR feeds branch logic.

## Interface
- OP_SIZE, 4, result width in bits
- DEPTH, 2, FIFO entries (fixed at 2; other values unsupported)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result offered
- in_ready  out  1  stage can accept
- in_r  in  OP_SIZE  ALU result
- in_flags  in  4  CVNZ flags from ALU, bit3=C, bit2=V, bit1=N, bit0=Z
- in_mask  in  4  flag update mask, same bit order; 1 = overwrite that flag
- out_ready  in  1  downstream (register file write port) can take a commit
- out_valid  out  1  one-cycle pulse, a commit happened on the previous edge
- acc  out  OP_SIZE  last committed result
- ccr  out  4  committed condition code register, CVNZ
- ccr_clr  in  1  clear CCR
- cond_sel  in  3  condition to evaluate
- cond_true  out  1  evaluation of cond_sel against ccr
- count  out  2  FIFO occupancy, 0..2

## Operation
- Accept: in_valid && in_ready at an edge pushes {in_r, in_flags, in_mask} at the tail.
- in_ready = !rst && (count < 2). This is combinational from rst and the registered count.
- Commit: at an edge with count > 0 && out_ready:
  - pop the head entry;
  - acc <= head.r;
  - ccr <= (ccr_base & ~head.mask) | (head.flags & head.mask);
  - out_valid <= 1.
- ccr_base is 0 if ccr_clr is high that cycle, otherwise the current ccr.
- At an edge with no commit: out_valid <= 0; ccr <= ccr_clr ? 0 : ccr.
- Push and pop in the same cycle: count is unchanged; head and tail pointers both advance. This can only occur with count = 1; at count = 2 in_ready is low.
- No bypass: a result pushed into an empty FIFO commits at the earliest on the following edge.
- in_flags and in_mask are not checked. Mask 0 commits acc only and leaves ccr unchanged.
- Pointers are 1 bit and wrap 1→0.
- cond_sel encodings (combinational on registered ccr):
  - 0 ALWAYS
  - 1 EQ (Z)
  - 2 NE (!Z)
  - 3 MI (N)
  - 4 PL (!N)
  - 5 CS (C)
  - 6 VS (V)
  - 7 GE (N==V)
- States, implied by count:
  - EMPTY (0): accept only.
  - ONE (1): accept and/or commit.
  - FULL (2): commit only.

## Timing
- Reset values: acc=0, ccr=0, out_valid=0, count=0, FIFO pointers=0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Reset mid-operation discards all buffered entries. No commit or push happens on a reset edge.
- Latency from accept edge to commit edge is ≥1 cycle. out_valid and the updated acc/ccr are visible in the cycle after the commit edge.
- Throughput is 1 commit per cycle while out_ready is held high.
- out_ready low stalls commits. The FIFO fills, and in_ready drops once count = 2.
- cond_true reflects ccr with zero cycles of combinational delay. It does not anticipate a pending commit.

## Structure
- Shared package alu_pkg holds:
  - flag indices C_BIT=3, V_BIT=2, N_BIT=1, Z_BIT=0;
  - masks C_MASK=4'b1000, V_MASK=4'b0100, N_MASK=4'b0010, Z_MASK=4'b0001;
  - cond_sel encodings COND_AL..COND_GE.
- The ALU modules use the same package so that their update masks match this stage.
- One sub-module, wb_fifo2: a 2-entry, width-parameterized FIFO providing push/pop/count/head.
- Flag merge and condition evaluation stay in the top module.

## Test plan
- Reset, then push r=4'b1010, flags=4'b0010, mask=4'b0011 with out_ready=1 → next edge commits; the cycle after shows acc=1010, ccr=0010, out_valid=1 for exactly one cycle.
- Masked merge: with ccr=1100, push OR result r=0000, flags=0001, mask=0011 → ccr=1101 (C, V preserved); cond_sel=1 gives cond_true=1.
- Backpressure: out_ready=0, push 3 results back-to-back → first two accepted, in_ready=0 at count=2; raise out_ready → commits in order on consecutive edges, acc sequence matches push order.
- Simultaneous push/pop at count=1 for 4 cycles → count stays 1, no entry lost or duplicated, pointer wrap exercised.
- ccr_clr asserted on a commit edge with flags=1000, mask=1000 → ccr=1000 (clear, then merge).
- Assert rst with count=2 mid-stream → all outputs at reset values next cycle; no out_valid pulse for the discarded entries.
